// File: rtl/jc_pkg.sv
// Shared definitions for the Johnson-code receive path.
//   dir_t        : movement encoding, identical to the counter's dir output
//   state_t      : decoder tracking state
//   decode_t     : {legal, phase} result of decoding one 4-bit code
//   DECODE_TABLE : code -> {legal, phase}, indexed by the raw 4-bit code
package jc_pkg;

  typedef enum logic [1:0] {
    STALL     = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_t;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    FAULT   = 2'd2
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [2:0] phase;
  } decode_t;

  // Only the eight Johnson states are legal; every other code decodes to
  // {legal=0, phase=0}.
  localparam decode_t DECODE_TABLE [16] = '{
    4'b1000,  // 0000 -> 0
    4'b1001,  // 0001 -> 1
    4'b0000,  // 0010
    4'b1010,  // 0011 -> 2
    4'b0000,  // 0100
    4'b0000,  // 0101
    4'b0000,  // 0110
    4'b1011,  // 0111 -> 3
    4'b1111,  // 1000 -> 7
    4'b0000,  // 1001
    4'b0000,  // 1010
    4'b0000,  // 1011
    4'b1110,  // 1100 -> 6
    4'b0000,  // 1101
    4'b1101,  // 1110 -> 5
    4'b1100   // 1111 -> 4
  };

endpackage

// File: rtl/jc_decoder_if.sv
// Bus between a Johnson-code source/consumer and jc_decoder.
//   q_in  : 4-bit Johnson code from the counter
//   clr   : synchronous clear of steps and err
//   pos   : decoded phase of the latest legal sample
//   dir   : movement of the latest sample (jc_pkg::dir_t encoding)
//   steps : signed net step count, STEP_W bits, two's complement
//   lock  : high while tracking
//   err   : sticky fault flag
// master drives q_in/clr, slave (the decoder) drives the results.
interface jc_decoder_if #(
  parameter int STEP_W = 16
);
  logic [3:0]        q_in;
  logic              clr;
  logic [2:0]        pos;
  logic [1:0]        dir;
  logic [STEP_W-1:0] steps;
  logic              lock;
  logic              err;

  modport master (output q_in, clr, input pos, dir, steps, lock, err);
  modport slave  (input q_in, clr, output pos, dir, steps, lock, err);
endinterface

// File: rtl/jc_phase_decode.sv
// Combinational Johnson-code decoder.
//   code  : 4-bit Johnson code
//   phase : phase 0..7 (0 when the code is illegal)
//   legal : 1 when code is one of the eight Johnson states
module jc_phase_decode
  import jc_pkg::*;
(
  input  logic [3:0] code,
  output logic [2:0] phase,
  output logic       legal
);

  decode_t entry;

  always_comb begin
    entry = DECODE_TABLE[code];
    phase = entry.phase;
    legal = entry.legal;
  end

endmodule

// File: rtl/jc_decoder.sv
// Receive-side decoder for the 4-bit bidirectional Johnson counter.
// Synchronizes q_in, decodes it to a phase, derives direction from
// consecutive legal phases, keeps a saturating signed step count and flags
// illegal codes / jumps once tracking has been established.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : jc_decoder_if slave (q_in, clr in; pos, dir, steps, lock, err out)
module jc_decoder
  import jc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int STEP_W      = 16,
  parameter int LOCK_COUNT  = 4
) (
  input logic         clk,
  input logic         rst_n,
  jc_decoder_if.slave bus
);

  localparam int unsigned   NSYNC    = SYNC_STAGES;
  localparam logic [3:0]    LOCK_N   = 4'(LOCK_COUNT);
  localparam logic [STEP_W-1:0] STEP_MAX = {1'b0, {(STEP_W-1){1'b1}}};
  localparam logic [STEP_W-1:0] STEP_MIN = {1'b1, {(STEP_W-1){1'b0}}};

  logic [3:0]        sync_q   [SYNC_STAGES];
  logic              sync_vld [SYNC_STAGES];
  logic [3:0]        cur;
  logic              cur_vld;
  logic [2:0]        cur_phase;
  logic              cur_legal;
  logic [2:0]        prev_phase;
  logic [2:0]        delta;
  logic              step_ok;

  state_t            state;
  logic [3:0]        run_cnt;
  logic [2:0]        pos_r;
  dir_t              dir_r;
  logic [STEP_W-1:0] steps_r;
  logic              lock_r;
  logic              err_r;

  // The reset contents of the synchronizer are not real samples; a parallel
  // valid shift keeps them from counting toward lock, so the first sample
  // acted on is the first q_in captured after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NSYNC; i++) begin
        sync_q[i]   <= '0;
        sync_vld[i] <= 1'b0;
      end
    end else begin
      sync_q[0]   <= bus.q_in;
      sync_vld[0] <= 1'b1;
      for (int unsigned i = 1; i < NSYNC; i++) begin
        sync_q[i]   <= sync_q[i-1];
        sync_vld[i] <= sync_vld[i-1];
      end
    end
  end

  assign cur     = sync_q[SYNC_STAGES-1];
  assign cur_vld = sync_vld[SYNC_STAGES-1];

  jc_phase_decode u_decode (
    .code  (cur),
    .phase (cur_phase),
    .legal (cur_legal)
  );

  // 3-bit subtraction gives the mod-8 delta directly, so 7->0 is +1.
  assign delta   = cur_phase - prev_phase;
  assign step_ok = cur_legal && (delta inside {3'd0, 3'd1, 3'd7});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ACQUIRE;
      run_cnt    <= '0;
      prev_phase <= '0;
      pos_r      <= '0;
      dir_r      <= STALL;
      steps_r    <= '0;
      lock_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      if (cur_vld) begin
        if (cur_legal) prev_phase <= cur_phase;
        unique case (state)
          ACQUIRE: begin
            dir_r  <= STALL;
            lock_r <= 1'b0;
            if (cur_legal) pos_r <= cur_phase;
            if (step_ok) begin
              run_cnt <= run_cnt + 4'd1;
              if ((run_cnt + 4'd1) == LOCK_N) begin
                state  <= TRACK;
                lock_r <= 1'b1;
              end
            end else begin
              run_cnt <= '0;
            end
          end
          TRACK: begin
            if (!step_ok) begin
              state  <= FAULT;
              lock_r <= 1'b0;
              dir_r  <= STALL;
              err_r  <= 1'b1;
            end else begin
              pos_r <= cur_phase;
              unique case (delta)
                3'd1: begin
                  dir_r <= DIR_LEFT;
                  if (steps_r != STEP_MAX) steps_r <= steps_r + 1'b1;
                end
                3'd7: begin
                  dir_r <= DIR_RIGHT;
                  if (steps_r != STEP_MIN) steps_r <= steps_r - 1'b1;
                end
                default: dir_r <= STALL;
              endcase
            end
          end
          FAULT: begin
            state   <= ACQUIRE;
            run_cnt <= '0;
            dir_r   <= STALL;
            lock_r  <= 1'b0;
            if (cur_legal) pos_r <= cur_phase;
          end
          default: begin
            state   <= ACQUIRE;
            run_cnt <= '0;
            dir_r   <= STALL;
            lock_r  <= 1'b0;
          end
        endcase
      end
      // Placed last so it overrides a same-edge step or fault flag while the
      // state transition above still takes effect.
      if (bus.clr) begin
        steps_r <= '0;
        err_r   <= 1'b0;
      end
    end
  end

  assign bus.pos   = pos_r;
  assign bus.dir   = dir_r;
  assign bus.steps = steps_r;
  assign bus.lock  = lock_r;
  assign bus.err   = err_r;

endmodule

// File: doc/jc_decoder.md
Name: jc_decoder

Overview:
Receive-side companion to the 4-bit bidirectional Johnson counter. Samples the counter's 4-bit Johnson code and decodes it to a phase 0..7. From consecutive samples it derives the movement direction and keeps a signed net step count. It flags illegal codes and illegal jumps, and sits between the counter outputs and any display or position logic.

Parameters:
SYNC_STAGES, 2, input synchronizer depth on q_in (legal 1..3)
STEP_W, 16, width of the signed step counter
LOCK_COUNT, 4, consecutive legal samples required before tracking (legal 1..15)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
q_in  in  4  Johnson code from the counter
clr  in  1  synchronous clear of steps and err (active high)
pos  out  3  decoded phase of latest legal sample
dir  out  2  movement in latest sample: 0 stall, 1 left (+1), 2 right (-1)
steps  out  STEP_W  signed net step count, two's complement
lock  out  1  high while in TRACK
err  out  1  sticky fault flag

Behaviour:
- Reset (rst_n=0 at an edge): pos=0, dir=0, steps=0, lock=0, err=0; FSM=ACQUIRE; synchronizer flops=0; prev phase=0; legal-run counter=0.
- Synchronizer: q_in passes through SYNC_STAGES flops; the last stage is "cur".
- Latency: a q_in value stable before edge k appears on pos/dir/steps after edge k+SYNC_STAGES.
- Decode table (cur -> phase): 0000->0, 0001->1, 0011->2, 0111->3, 1111->4, 1110->5, 1100->6, 1000->7.
- All other 8 codes are illegal.
- Delta = (phase_cur - phase_prev) mod 8, computed on legal samples only:
  - delta 0: stall.
  - delta 1: left.
  - delta 7: right.
  - delta 2..6: jump (illegal).
- prev phase updates only on legal codes.
- FSM ACQUIRE:
  - lock=0, dir=0, steps frozen.
  - A legal code with a non-jump delta increments the run counter.
  - An illegal code or a jump zeroes the run counter; err is not set.
  - When the run counter reaches LOCK_COUNT, the next state is TRACK.
  - pos follows the latest legal phase.
- FSM TRACK:
  - lock=1; pos updates every legal sample.
  - dir = 0/1/2 per delta.
  - steps increments on left and decrements on right.
  - steps saturates at +(2^(STEP_W-1)-1) and -(2^(STEP_W-1)); it never wraps.
- TRACK to FAULT: an illegal code or jump sets err=1, lock=0, dir=0. pos holds its last legal value.
- FAULT: lasts exactly one cycle, then ACQUIRE with the run counter at 0.
- Phase wrap: 7->0 is left (+1); 0->7 is right (-1).
- clr=1:
  - steps=0 and err=0 at that edge.
  - clr wins over a simultaneous step and over simultaneous fault detection (err stays 0 for that edge). The FSM transition still occurs.
  - clr does not affect FSM, pos, dir or the synchronizer.
- rst_n=0 mid-operation overrides everything, including clr, and returns all state to reset values at that edge.

Decomposition:
- Shared package jc_pkg:
  - direction constants STALL=0, DIR_LEFT=1, DIR_RIGHT=2, matching the counter's dir encoding.
  - FSM state encoding ACQUIRE/TRACK/FAULT.
  - 16-entry decode constant (code -> {legal, phase}).
- One natural sub-module: jc_phase_decode, combinational 4-bit code -> 3-bit phase + legal bit. It is reused by the counter's future self-check.
- Synchronizer, delta logic, FSM and step counter stay in jc_decoder.

Test Plan:
- Reset and acquire:
  - Stimulus: rst_n low 2 cycles, then q_in=0000 held.
  - Response: all outputs 0; lock rises after LOCK_COUNT+SYNC_STAGES edges (6 with defaults); dir=0, steps=0.
- Left sweep:
  - Stimulus: after lock, step q_in through 0001,0011,0111,1111,1110,1100,1000,0000, one per cycle.
  - Response: pos 1..7 then 0; dir=1 each step; steps=8 (wrap 7->0 counted +1).
- Right sweep:
  - Stimulus: from steps=8 at phase 0, step q_in through 1000,1100,1110,1111,0111,0011,0001,0000, then 1000.
  - Response: pos 7..1, 0, 7; dir=2 each step; steps=-1.
- Illegal code:
  - Stimulus: in TRACK, q_in=0101 for 1 cycle, then back to the last legal code.
  - Response: err=1, lock=0, dir=0, pos held; ACQUIRE follows; lock returns after 4 legal samples; err stays 1.
- Jump and clear:
  - Stimulus: in TRACK at phase 1, q_in 0001->0111 (delta 2).
  - Response: err=1. Then clr=1 for one cycle gives err=0 and steps=0.
  - Stimulus: clr together with a left step.
  - Response: steps=0, not 1.
- Saturation:
  - Stimulus: STEP_W=4, 10 left steps in TRACK.
  - Response: steps stops at +7 (0111) and dir still reports 1.
  - Stimulus: 20 right steps.
  - Response: steps stops at -8 (1000).
